// File: rtl/fp_csr_pkg.sv
// Shared types and constants for the floating-point CSR sequencer:
// CSR addresses, rounding modes, request op encodings and FSM states.
package fp_csr_pkg;

    typedef enum logic [11:0] {
        CSR_FFLAGS = 12'h001,
        CSR_FRM    = 12'h002,
        CSR_FCSR   = 12'h003
    } csr_addr_e;

    typedef enum logic [2:0] {
        RM_RNE  = 3'b000,
        RM_RTZ  = 3'b001,
        RM_RDN  = 3'b010,
        RM_RUP  = 3'b011,
        RM_RMM  = 3'b100,
        RM_RSV5 = 3'b101,
        RM_RSV6 = 3'b110,
        RM_DYN  = 3'b111
    } rm_e;

    typedef enum logic [1:0] {
        OP_RW  = 2'b00,
        OP_RS  = 2'b01,
        OP_RC  = 2'b10,
        OP_ILL = 2'b11
    } req_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_READ,
        S_WRITE,
        S_RESP
    } state_e;

    // Writable bits of each FP CSR; anything outside them reads/writes as zero.
    function automatic logic [31:0] csr_mask(input logic [11:0] addr);
        case (addr)
            CSR_FFLAGS: csr_mask = 32'h0000_001F;
            CSR_FRM:    csr_mask = 32'h0000_0007;
            CSR_FCSR:   csr_mask = 32'h0000_00FF;
            default:    csr_mask = '0;
        endcase
    endfunction

    function automatic logic csr_legal(input logic [11:0] addr, input logic [1:0] op);
        csr_legal = (op != OP_ILL) &&
                    ((addr == CSR_FFLAGS) || (addr == CSR_FRM) || (addr == CSR_FCSR));
    endfunction

endpackage

// File: rtl/fp_flag_merge.sv
// Registered one-cycle merge of exception flags from the FP ALU and the
// div/sqrt unit into a single accumulate pulse.
module fp_flag_merge (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] a_flags_i,
    input  logic       a_valid_i,
    input  logic [4:0] b_flags_i,
    input  logic       b_valid_i,
    output logic [4:0] flags_o,
    output logic       valid_o
);

    logic [4:0] flags_q;
    logic       valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= a_valid_i | b_valid_i;
            flags_q <= (a_valid_i ? a_flags_i : 5'b0) | (b_valid_i ? b_flags_i : 5'b0);
        end
    end

    assign flags_o = flags_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fp_csr_sequencer.sv
// Read-modify-write sequencer for fflags/frm/fcsr with in-flight drain, issue
// stall, flag merge and dynamic rounding-mode resolution.
// Optional: `define FP_CSR_SEQ_FS_DIRTY_EN adds the fs_dirty_set output.
module fp_csr_sequencer
    import fp_csr_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_wr_suppress,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    input  logic        fp_issue,
    input  logic        fp_retire,
    output logic        fp_issue_stall,
    input  logic [4:0]  fflags_a_in,
    input  logic        fflags_a_valid,
    input  logic [4:0]  fflags_b_in,
    input  logic        fflags_b_valid,
    output logic        csr_write,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic [4:0]  fflags_out,
    output logic        fflags_out_valid,
    input  logic [2:0]  frm_cur,
    input  logic [2:0]  inst_rm,
    output logic [2:0]  eff_rm,
    output logic        rm_illegal
`ifdef FP_CSR_SEQ_FS_DIRTY_EN
    ,
    output logic        fs_dirty_set
`endif
);

    localparam int unsigned   CW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    state_e        state_q, state_d;
    req_op_e       op_q, op_d;
    logic [11:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          sup_q, sup_d;
    logic [31:0]   old_q, old_d;
    logic [CW-1:0] count_q, count_d;
    logic          csr_write_q, csr_write_d;
    logic [31:0]   csr_wdata_q, csr_wdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_illegal_q, resp_illegal_d;

    logic          issue_ok, retire_ok, drained;
    logic [31:0]   new_val;

    fp_flag_merge u_flag_merge (
        .clk_i     (clock),
        .rst_i     (reset),
        .a_flags_i (fflags_a_in),
        .a_valid_i (fflags_a_valid),
        .b_flags_i (fflags_b_in),
        .b_valid_i (fflags_b_valid),
        .flags_o   (fflags_out),
        .valid_o   (fflags_out_valid)
    );

    // Retire at zero is dropped, so a same-cycle issue still counts.
    assign issue_ok  = fp_issue && (count_q != CNT_MAX);
    assign retire_ok = fp_retire && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (issue_ok && !retire_ok) begin
            count_d = count_q + CW'(1);
        end else if (retire_ok && !issue_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    assign drained = (count_q == '0) && !fflags_out_valid && !fflags_a_valid && !fflags_b_valid;

    always_comb begin
        case (op_q)
            OP_RW:   new_val = wdata_q;
            OP_RS:   new_val = csr_rdata | wdata_q;
            default: new_val = csr_rdata & ~wdata_q;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        sup_d          = sup_q;
        old_d          = old_q;
        csr_write_d    = 1'b0;
        csr_wdata_d    = '0;
        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_illegal_d = resp_illegal_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op_e'(req_op);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    sup_d   = req_wr_suppress;
                    if (!csr_legal(req_addr, req_op)) begin
                        state_d        = S_RESP;
                        resp_valid_d   = 1'b1;
                        resp_illegal_d = 1'b1;
                        resp_rdata_d   = '0;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_READ;
                end
            end
            // Write data and strobe are registered here so they appear during WRITE.
            S_READ: begin
                old_d       = csr_rdata;
                csr_wdata_d = new_val & csr_mask(addr_q);
                csr_write_d = (op_q == OP_RW) || !sup_q;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                state_d        = S_RESP;
                resp_valid_d   = 1'b1;
                resp_illegal_d = 1'b0;
                resp_rdata_d   = old_q;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d        = S_IDLE;
                    resp_valid_d   = 1'b0;
                    resp_illegal_d = 1'b0;
                    resp_rdata_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_q           <= OP_RW;
            addr_q         <= '0;
            wdata_q        <= '0;
            sup_q          <= 1'b0;
            old_q          <= '0;
            count_q        <= '0;
            csr_write_q    <= 1'b0;
            csr_wdata_q    <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            sup_q          <= sup_d;
            old_q          <= old_d;
            count_q        <= count_d;
            csr_write_q    <= csr_write_d;
            csr_wdata_q    <= csr_wdata_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign fp_issue_stall = (state_q != S_IDLE) || (count_q == CNT_MAX);
    assign csr_addr       = ((state_q == S_DRAIN) || (state_q == S_READ) || (state_q == S_WRITE))
                            ? addr_q : 12'h000;
    assign csr_write      = csr_write_q;
    assign csr_wdata      = csr_wdata_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_illegal   = resp_illegal_q;

    assign eff_rm     = (inst_rm == RM_DYN) ? frm_cur : inst_rm;
    assign rm_illegal = (eff_rm == RM_RSV5) || (eff_rm == RM_RSV6) || (eff_rm == RM_DYN);

`ifdef FP_CSR_SEQ_FS_DIRTY_EN
    assign fs_dirty_set = csr_write_q | (fflags_out_valid & (|fflags_out));
`endif

endmodule

// File: tb/tb_fp_csr_sequencer.sv
// Directed self-checking bench for fp_csr_sequencer with a behavioural
// fflags/frm register model on the CSR side.
module tb_fp_csr_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_wr_suppress;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic        fp_issue, fp_retire, fp_issue_stall;
    logic [4:0]  fflags_a_in, fflags_b_in;
    logic        fflags_a_valid, fflags_b_valid;
    logic        csr_write;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic [4:0]  fflags_out;
    logic        fflags_out_valid;
    logic [2:0]  frm_cur, inst_rm, eff_rm;
    logic        rm_illegal;
`ifdef FP_CSR_SEQ_FS_DIRTY_EN
    logic        fs_dirty_set;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [4:0]  m_fflags;
    logic [2:0]  m_frm;
    int          wr_cnt   = 0;
    int          inv_viol = 0;
    logic [31:0] last_wdata = '0;

    always #5 clock = ~clock;

    fp_csr_sequencer #(.MAX_INFLIGHT(7)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_wr_suppress  (req_wr_suppress),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_illegal     (resp_illegal),
        .fp_issue         (fp_issue),
        .fp_retire        (fp_retire),
        .fp_issue_stall   (fp_issue_stall),
        .fflags_a_in      (fflags_a_in),
        .fflags_a_valid   (fflags_a_valid),
        .fflags_b_in      (fflags_b_in),
        .fflags_b_valid   (fflags_b_valid),
        .csr_write        (csr_write),
        .csr_addr         (csr_addr),
        .csr_wdata        (csr_wdata),
        .csr_rdata        (csr_rdata),
        .fflags_out       (fflags_out),
        .fflags_out_valid (fflags_out_valid),
        .frm_cur          (frm_cur),
        .inst_rm          (inst_rm),
        .eff_rm           (eff_rm),
        .rm_illegal       (rm_illegal)
`ifdef FP_CSR_SEQ_FS_DIRTY_EN
        ,
        .fs_dirty_set     (fs_dirty_set)
`endif
    );

    // CSR-side register model, updated mid-cycle where all DUT outputs are stable.
    always @(negedge clock) begin
        if (csr_write) begin
            wr_cnt++;
            last_wdata = csr_wdata;
            case (csr_addr)
                12'h001: m_fflags = csr_wdata[4:0];
                12'h002: m_frm    = csr_wdata[2:0];
                12'h003: {m_frm, m_fflags} = csr_wdata[7:0];
                default: ;
            endcase
        end
        if (fflags_out_valid) m_fflags = m_fflags | fflags_out;
        if (csr_write && fflags_out_valid) inv_viol++;
    end

    always_comb begin
        case (csr_addr)
            12'h001: csr_rdata = {27'b0, m_fflags};
            12'h002: csr_rdata = {29'b0, m_frm};
            12'h003: csr_rdata = {24'b0, m_frm, m_fflags};
            default: csr_rdata = '0;
        endcase
    end
    assign frm_cur = m_frm;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] wd, input logic sup);
        logic accepted;
        accepted        = 1'b0;
        req_valid       = 1'b1;
        req_op          = op;
        req_addr        = addr;
        req_wdata       = wd;
        req_wr_suppress = sup;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (req_ready) accepted = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        check_eq("req_accepted", {31'b0, accepted}, 32'd1);
    endtask

    task automatic wait_resp(output logic [31:0] rdata, output logic ill);
        int n;
        n = 0;
        while (!resp_valid && n < 60) begin
            tick();
            n++;
        end
        check_eq("resp_arrived", {31'b0, resp_valid}, 32'd1);
        rdata      = resp_rdata;
        ill        = resp_illegal;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_eq("resp_released", {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic pulse_issue(input int n);
        fp_issue = 1'b1;
        repeat (n) tick();
        fp_issue = 1'b0;
    endtask

    task automatic pulse_retire(input int n);
        fp_retire = 1'b1;
        repeat (n) tick();
        fp_retire = 1'b0;
    endtask

    logic [31:0] rd;
    logic        ill;
    int          w0;

    initial begin
        req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_wr_suppress = 0;
        resp_ready = 0; fp_issue = 0; fp_retire = 0;
        fflags_a_in = 0; fflags_a_valid = 0; fflags_b_in = 0; fflags_b_valid = 0;
        inst_rm = 3'b000;
        m_fflags = 5'h00;
        m_frm    = 3'b000;

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_csr_write",   {31'b0, csr_write},        32'd0);
        check_eq("rst_resp_valid",  {31'b0, resp_valid},       32'd0);
        check_eq("rst_resp_rdata",  resp_rdata,                32'd0);
        check_eq("rst_resp_ill",    {31'b0, resp_illegal},     32'd0);
        check_eq("rst_fflags_vld",  {31'b0, fflags_out_valid}, 32'd0);
        check_eq("rst_fflags_out",  {27'b0, fflags_out},       32'd0);
        check_eq("rst_req_ready",   {31'b0, req_ready},        32'd1);
        check_eq("rst_stall",       {31'b0, fp_issue_stall},   32'd0);
        check_eq("rst_csr_addr",    {20'b0, csr_addr},         32'd0);
        reset = 1'b0;
        tick();

        inst_rm = 3'b111; #1;
        check_eq("rm_dyn_rne",     {29'b0, eff_rm},       32'd0);
        check_eq("rm_dyn_rne_ill", {31'b0, rm_illegal},   32'd0);

        // RW frm=3 with suppress set: RW ignores suppress. Exact T0..T3 timing.
        check_eq("t1_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1; req_op = 2'b00; req_addr = 12'h002; req_wdata = 32'h3; req_wr_suppress = 1;
        tick();
        req_valid = 0;
        check_eq("t1_drain_addr",  {20'b0, csr_addr},       32'h002);
        check_eq("t1_drain_stall", {31'b0, fp_issue_stall}, 32'd1);
        check_eq("t1_drain_nresp", {31'b0, resp_valid},     32'd0);
        tick();
        check_eq("t1_read_nowr",   {31'b0, csr_write},      32'd0);
        check_eq("t1_read_addr",   {20'b0, csr_addr},       32'h002);
        tick();
        check_eq("t1_write_en",    {31'b0, csr_write},      32'd1);
        check_eq("t1_write_data",  csr_wdata,               32'h3);
        tick();
        check_eq("t1_resp_valid",  {31'b0, resp_valid},     32'd1);
        check_eq("t1_resp_rdata",  resp_rdata,              32'h0);
        check_eq("t1_resp_ill",    {31'b0, resp_illegal},   32'd0);
        check_eq("t1_write_gone",  {31'b0, csr_write},      32'd0);
        wait_resp(rd, ill);
        check_eq("t1_frm_written", {29'b0, m_frm},          32'h3);
        check_eq("t1_wr_cnt",      wr_cnt,                  32'd1);
        check_eq("t1_idle_addr",   {20'b0, csr_addr},       32'h0);
        check_eq("t1_rm_dyn",      {29'b0, eff_rm},         32'h3);

        // RS read-only, then RC clearing bit 0.
        m_fflags = 5'h05;
        w0 = wr_cnt;
        send_req(2'b01, 12'h001, 32'h0, 1'b1);
        wait_resp(rd, ill);
        check_eq("t2_rs_rdata",   rd,            32'h05);
        check_eq("t2_rs_nowrite", wr_cnt - w0,   32'd0);
        send_req(2'b10, 12'h001, 32'h01, 1'b0);
        wait_resp(rd, ill);
        check_eq("t2_rc_rdata",   rd,            32'h05);
        check_eq("t2_rc_wdata",   last_wdata,    32'h04);
        check_eq("t2_rc_wrcnt",   wr_cnt - w0,   32'd1);

        // Drain: three in flight, then flags arrive with the last retire.
        m_fflags = 5'h00;
        pulse_issue(3);
        check_eq("t3_stall_pre", {31'b0, fp_issue_stall}, 32'd0);
        w0 = wr_cnt;
        send_req(2'b01, 12'h001, 32'h02, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq("t3_drain_stall", {31'b0, fp_issue_stall}, 32'd1);
            check_eq("t3_drain_nresp", {31'b0, resp_valid},     32'd0);
            tick();
        end
        fp_retire = 1'b1;
        tick();
        tick();
        fflags_a_valid = 1'b1; fflags_a_in = 5'h10;
        tick();
        fp_retire = 1'b0; fflags_a_valid = 1'b0; fflags_a_in = 5'h00;
        check_eq("t3_flag_pulse",  {31'b0, fflags_out_valid}, 32'd1);
        check_eq("t3_no_early_wr", wr_cnt - w0,               32'd0);
        wait_resp(rd, ill);
        check_eq("t3_rdata",  rd,          32'h10);
        check_eq("t3_wdata",  last_wdata,  32'h12);
        check_eq("t3_wrcnt",  wr_cnt - w0, 32'd1);

        // Flag merge.
        fflags_a_valid = 1; fflags_a_in = 5'h01; fflags_b_valid = 1; fflags_b_in = 5'h08;
        tick();
        fflags_a_valid = 0; fflags_b_valid = 0;
        check_eq("fm_both_valid", {31'b0, fflags_out_valid}, 32'd1);
        check_eq("fm_both_flags", {27'b0, fflags_out},       32'h09);
        tick();
        check_eq("fm_single_pulse", {31'b0, fflags_out_valid}, 32'd0);
        fflags_a_valid = 1; fflags_a_in = 5'h00; fflags_b_in = 5'h1F;
        tick();
        fflags_a_valid = 0;
        check_eq("fm_zero_valid", {31'b0, fflags_out_valid}, 32'd1);
        check_eq("fm_zero_flags", {27'b0, fflags_out},       32'h00);
        fflags_b_valid = 1; fflags_b_in = 5'h02; fflags_a_in = 5'h1F;
        tick();
        fflags_b_valid = 0;
        check_eq("fm_b_only", {27'b0, fflags_out}, 32'h02);
        tick();

        // Inflight counter limits.
        pulse_issue(6);
        check_eq("cnt_6_nostall", {31'b0, fp_issue_stall}, 32'd0);
        fp_issue = 1; fp_retire = 1;
        tick();
        fp_issue = 0; fp_retire = 0;
        check_eq("cnt_same_cycle", {31'b0, fp_issue_stall}, 32'd0);
        pulse_issue(1);
        check_eq("cnt_7_stall", {31'b0, fp_issue_stall}, 32'd1);
        pulse_issue(1);
        check_eq("cnt_blocked_issue", {31'b0, fp_issue_stall}, 32'd1);
        pulse_retire(1);
        check_eq("cnt_6_again", {31'b0, fp_issue_stall}, 32'd0);
        pulse_retire(7);
        check_eq("cnt_retire_at_0", {31'b0, fp_issue_stall}, 32'd0);
        pulse_issue(6);
        check_eq("cnt_nowrap_6", {31'b0, fp_issue_stall}, 32'd0);
        pulse_issue(1);
        check_eq("cnt_nowrap_7", {31'b0, fp_issue_stall}, 32'd1);
        pulse_retire(7);

        // Illegal accesses and reserved rounding modes.
        w0 = wr_cnt;
        send_req(2'b00, 12'h300, 32'hFFFF_FFFF, 1'b0);
        wait_resp(rd, ill);
        check_eq("ill_addr_flag",  {31'b0, ill}, 32'd1);
        check_eq("ill_addr_rdata", rd,           32'h0);
        send_req(2'b11, 12'h001, 32'h1, 1'b0);
        wait_resp(rd, ill);
        check_eq("ill_op_flag",    {31'b0, ill}, 32'd1);
        check_eq("ill_nowrite",    wr_cnt - w0,  32'd0);
        m_frm = 3'b101; inst_rm = 3'b111; #1;
        check_eq("rm_dyn_rsv",     {29'b0, eff_rm},     32'h5);
        check_eq("rm_dyn_rsv_ill", {31'b0, rm_illegal}, 32'd1);
        inst_rm = 3'b100; #1;
        check_eq("rm_static",      {29'b0, eff_rm},     32'h4);
        check_eq("rm_static_ill",  {31'b0, rm_illegal}, 32'd0);
        inst_rm = 3'b110; #1;
        check_eq("rm_static_rsv",  {31'b0, rm_illegal}, 32'd1);

        // fcsr write is masked to 8 bits.
        m_fflags = 5'h00;
        send_req(2'b00, 12'h003, 32'hFFFF_FFFF, 1'b0);
        wait_resp(rd, ill);
        check_eq("fcsr_rdata", rd,              32'hA0);
        check_eq("fcsr_wdata", last_wdata,      32'hFF);
        check_eq("fcsr_frm",   {29'b0, m_frm},  32'h7);
        inst_rm = 3'b111; #1;
        check_eq("rm_dyn7_ill", {31'b0, rm_illegal}, 32'd1);

        // Reset while draining abandons the access.
        pulse_issue(2);
        w0 = wr_cnt;
        send_req(2'b00, 12'h002, 32'h1, 1'b0);
        tick();
        check_eq("rs_pre_stall", {31'b0, fp_issue_stall}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rs_async_ready", {31'b0, req_ready},  32'd1);
        check_eq("rs_async_nowr",  {31'b0, csr_write},  32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("rs_ready",     {31'b0, req_ready},      32'd1);
        check_eq("rs_cnt_zero",  {31'b0, fp_issue_stall}, 32'd0);
        repeat (6) tick();
        check_eq("rs_nowrite",   wr_cnt - w0,             32'd0);
        check_eq("rs_frm_kept",  {29'b0, m_frm},          32'h7);
        check_eq("inv_write_vs_flags", inv_viol,          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
